// File: rtl/crc_feeder_pkg.sv
// Shared constants for the CRC stream feeder: APB register map,
// CTRL field positions, CRC mode encodings and feeder FSM states.
package crc_feeder_pkg;

    localparam logic [31:0] OFF_CTRL = 32'h00;
    localparam logic [31:0] OFF_INIT = 32'h04;
    localparam logic [31:0] OFF_XORV = 32'h08;
    localparam logic [31:0] OFF_DATA = 32'h0C;
    localparam logic [31:0] OFF_STAT = 32'h10;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_REVIN  = 1;
    localparam int CTRL_REVOUT = 2;
    localparam int CTRL_MODE   = 3;
    localparam int CTRL_SIZE   = 5;

    typedef enum logic [1:0] {
        MODE_CRC8       = 2'd0,
        MODE_CRC16_1021 = 2'd1,
        MODE_CRC16_8005 = 2'd2,
        MODE_CRC32      = 2'd3
    } crc_mode_e;

    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_PACK    = 4'd1;
    localparam logic [3:0] ST_WR_INIT = 4'd2;
    localparam logic [3:0] ST_WR_XORV = 4'd3;
    localparam logic [3:0] ST_WR_CTRL = 4'd4;
    localparam logic [3:0] ST_WR_DATA = 4'd5;
    localparam logic [3:0] ST_POLL    = 4'd6;
    localparam logic [3:0] ST_RD_DATA = 4'd7;
    localparam logic [3:0] ST_RESULT  = 4'd8;
    localparam logic [3:0] ST_DRAIN   = 4'd9;

    function automatic logic [31:0] mask_to_mode(
        input logic [1:0]  mode,
        input logic [31:0] v
    );
        logic [31:0] r;
        case (mode)
            MODE_CRC8:       r = {24'h0, v[7:0]};
            MODE_CRC16_1021,
            MODE_CRC16_8005: r = {16'h0, v[15:0]};
            default:         r = v;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] ctrl_word(
        input logic       revin,
        input logic       revout,
        input logic [1:0] mode,
        input logic [1:0] size
    );
        logic [31:0] w;
        w = 32'h0;
        w[CTRL_EN]     = 1'b1;
        w[CTRL_REVIN]  = revin;
        w[CTRL_REVOUT] = revout;
        w[CTRL_MODE +: 2] = mode;
        w[CTRL_SIZE +: 2] = size;
        return w;
    endfunction

endpackage

// File: rtl/apb4_master_xfer.sv
// Single-transfer APB4 master: req launches SETUP then ACCESS until pready.
// Ports: req/write/addr/wdata in; busy, done pulse, rdata, err out; APB pins.
module apb4_master_xfer (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err,
    output logic [31:0] paddr,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] pwdata,
    input  logic [31:0] prdata,
    input  logic        pready,
    input  logic        pslverr
);

    assign busy = psel;

    always_ff @(posedge clk) begin
        if (rst) begin
            paddr   <= 32'h0;
            psel    <= 1'b0;
            penable <= 1'b0;
            pwrite  <= 1'b0;
            pwdata  <= 32'h0;
            done    <= 1'b0;
            rdata   <= 32'h0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (!psel) begin
                if (req) begin
                    psel   <= 1'b1;
                    paddr  <= addr;
                    pwrite <= write;
                    pwdata <= write ? wdata : 32'h0;
                end
            end else if (!penable) begin
                penable <= 1'b1;
            end else if (pready) begin
                psel    <= 1'b0;
                penable <= 1'b0;
                done    <= 1'b1;
                rdata   <= prdata;
                err     <= pslverr;
            end
        end
    end

endmodule

// File: rtl/crc_stream_feeder.sv
// Packs a framed byte stream into 1-4 byte chunks and chains them through
// the APB CRC peripheral; returns one final CRC per frame on res_*.
// Ports: cfg_* frame config, s_* byte stream, res_* result, p* APB master.
module crc_stream_feeder
    import crc_feeder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          POLL_MAX  = 16
) (
    input  logic        pclk_i,
    input  logic        prst_i,
    input  logic [1:0]  cfg_mode_i,
    input  logic        cfg_revin_i,
    input  logic        cfg_revout_i,
    input  logic [31:0] cfg_init_i,
    input  logic [31:0] cfg_xorv_i,
    input  logic        s_valid_i,
    output logic        s_ready_o,
    input  logic [7:0]  s_data_i,
    input  logic        s_last_i,
    output logic        res_valid_o,
    input  logic        res_ready_i,
    output logic [31:0] res_data_o,
    output logic        res_err_o,
    output logic        busy_o,
    output logic [31:0] paddr_o,
    output logic        psel_o,
    output logic        penable_o,
    output logic        pwrite_o,
    output logic [31:0] pwdata_o,
    input  logic [31:0] prdata_i,
    input  logic        pready_i,
    input  logic        pslverr_i
);

    localparam int PW = $clog2(POLL_MAX + 1);
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_MAX - 1);

    logic [3:0]    state;
    logic [1:0]    mode_q;
    logic          revin_q;
    logic          revout_q;
    logic [31:0]   init_q;
    logic [31:0]   xorv_q;
    logic [31:0]   chunk_q;
    logic [31:0]   chain_q;
    logic [31:0]   res_q;
    logic [2:0]    cnt_q;
    logic          first_q;
    logic          final_q;
    logic          err_q;
    logic [PW-1:0] poll_q;

    logic          x_need;
    logic          x_req;
    logic          x_write;
    logic [31:0]   x_off;
    logic [31:0]   x_wdata;
    logic          x_busy;
    logic          x_done;
    logic [31:0]   x_rdata;
    logic          x_err;

    always_comb begin
        x_need  = 1'b1;
        x_write = 1'b1;
        x_off   = OFF_CTRL;
        x_wdata = 32'h0;
        case (state)
            ST_WR_INIT: begin
                x_off   = OFF_INIT;
                x_wdata = first_q ? init_q : chain_q;
            end
            ST_WR_XORV: begin
                x_off   = OFF_XORV;
                x_wdata = final_q ? xorv_q : 32'h0;
            end
            ST_WR_CTRL: begin
                x_off   = OFF_CTRL;
                // cnt 4 wraps to size 3 in two bits
                x_wdata = ctrl_word(revin_q, final_q & revout_q,
                                    mode_q, cnt_q[1:0] - 2'd1);
            end
            ST_WR_DATA: begin
                x_off   = OFF_DATA;
                x_wdata = chunk_q;
            end
            ST_POLL: begin
                x_write = 1'b0;
                x_off   = OFF_STAT;
            end
            ST_RD_DATA: begin
                x_write = 1'b0;
                x_off   = OFF_DATA;
            end
            default: x_need = 1'b0;
        endcase
    end

    // One launch per visit: the done cycle masks req so the state can move on.
    assign x_req = x_need & ~x_busy & ~x_done;

    apb4_master_xfer u_xfer (
        .clk     (pclk_i),
        .rst     (prst_i),
        .req     (x_req),
        .write   (x_write),
        .addr    (BASE_ADDR + x_off),
        .wdata   (x_wdata),
        .busy    (x_busy),
        .done    (x_done),
        .rdata   (x_rdata),
        .err     (x_err),
        .paddr   (paddr_o),
        .psel    (psel_o),
        .penable (penable_o),
        .pwrite  (pwrite_o),
        .pwdata  (pwdata_o),
        .prdata  (prdata_i),
        .pready  (pready_i),
        .pslverr (pslverr_i)
    );

    assign s_ready_o   = (state == ST_PACK) || (state == ST_DRAIN);
    assign res_valid_o = (state == ST_RESULT);
    assign res_data_o  = res_q;
    assign res_err_o   = err_q;
    assign busy_o      = (state != ST_IDLE);

    always_ff @(posedge pclk_i) begin
        if (prst_i) begin
            state    <= ST_IDLE;
            mode_q   <= 2'd0;
            revin_q  <= 1'b0;
            revout_q <= 1'b0;
            init_q   <= 32'h0;
            xorv_q   <= 32'h0;
            chunk_q  <= 32'h0;
            chain_q  <= 32'h0;
            res_q    <= 32'h0;
            cnt_q    <= 3'd0;
            first_q  <= 1'b0;
            final_q  <= 1'b0;
            err_q    <= 1'b0;
            poll_q   <= '0;
        end else begin
            case (state)
                ST_IDLE: if (s_valid_i) begin
                    mode_q   <= cfg_mode_i;
                    revin_q  <= cfg_revin_i;
                    revout_q <= cfg_revout_i;
                    init_q   <= cfg_init_i;
                    xorv_q   <= cfg_xorv_i;
                    err_q    <= 1'b0;
                    first_q  <= 1'b1;
                    final_q  <= 1'b0;
                    cnt_q    <= 3'd0;
                    chunk_q  <= 32'h0;
                    state    <= ST_PACK;
                end
                ST_PACK: if (s_valid_i) begin
                    chunk_q <= {chunk_q[23:0], s_data_i};
                    cnt_q   <= cnt_q + 3'd1;
                    if (cnt_q == 3'd3 || s_last_i) begin
                        final_q <= s_last_i;
                        state   <= ST_WR_INIT;
                    end
                end
                ST_WR_INIT: if (x_done) begin
                    err_q <= err_q | x_err;
                    state <= ST_WR_XORV;
                end
                ST_WR_XORV: if (x_done) begin
                    err_q <= err_q | x_err;
                    state <= ST_WR_CTRL;
                end
                ST_WR_CTRL: if (x_done) begin
                    err_q <= err_q | x_err;
                    state <= ST_WR_DATA;
                end
                ST_WR_DATA: if (x_done) begin
                    err_q  <= err_q | x_err;
                    poll_q <= '0;
                    state  <= ST_POLL;
                end
                ST_POLL: if (x_done) begin
                    err_q <= err_q | x_err;
                    if (x_rdata[0]) begin
                        state <= ST_RD_DATA;
                    end else if (poll_q == POLL_LAST) begin
                        err_q <= 1'b1;
                        res_q <= 32'h0;
                        state <= final_q ? ST_RESULT : ST_DRAIN;
                    end else begin
                        poll_q <= poll_q + 1'b1;
                    end
                end
                ST_RD_DATA: if (x_done) begin
                    err_q <= err_q | x_err;
                    if (final_q) begin
                        res_q <= mask_to_mode(mode_q, x_rdata);
                        state <= ST_RESULT;
                    end else begin
                        chain_q <= x_rdata;
                        first_q <= 1'b0;
                        cnt_q   <= 3'd0;
                        chunk_q <= 32'h0;
                        state   <= ST_PACK;
                    end
                end
                ST_DRAIN: if (s_valid_i && s_last_i) begin
                    state <= ST_RESULT;
                end
                ST_RESULT: if (res_ready_i) begin
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
